onewire_sequencer: RTL and testbench

Synthesizable 1-wire bus master sequencer at standard speed. It takes RESET, BYTE and BIT commands over a valid/ready interface and generates the reset/presence and read/write time-slot waveforms on an open-drain line. It returns the presence flag or the sampled data. It sits between a host register interface and the pulled-up `owr` line, and is the RTL counterpart of the behavioural master used in the onewire benches.

---
 rtl/onewire_pkg.sv | 27 ++
 rtl/onewire_tick.sv | 29 ++
 rtl/onewire_sequencer.sv | 168 ++++++++++++++++
 tb/tb_onewire_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// Shared types and standard-speed 1-wire timing constants (in microsecond ticks)
// for the onewire sequencer.
package onewire_pkg;

    typedef enum logic [1:0] {
        CMD_RESET = 2'd0,
        CMD_BYTE  = 2'd1,
        CMD_BIT   = 2'd2,
        CMD_NOP   = 2'd3
    } cmd_typ_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        SLOT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [9:0] T_RST_LOW = 10'd480;
    localparam logic [9:0] T_RST_SMP = 10'd550;
    localparam logic [9:0] T_RST_END = 10'd960;
    localparam logic [9:0] T_W1_LOW  = 10'd6;
    localparam logic [9:0] T_W0_LOW  = 10'd60;
    localparam logic [9:0] T_SMP     = 10'd15;
    localparam logic [9:0] T_SLOT    = 10'd70;

endpackage

// File: rtl/onewire_tick.sv
// Microsecond prescaler: one-cycle tick every CDR clocks, restartable by a
// synchronous clear so ticks stay aligned to command acceptance.
module onewire_tick #(
    parameter int CDR = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(CDR);
    localparam logic [W-1:0] LAST = W'(CDR - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/onewire_sequencer.sv
// 1-wire bus master: runs RESET/BYTE/BIT/NOP commands as reset-presence and
// read/write time slots on an open-drain line, returning presence or read data.
module onewire_sequencer
    import onewire_pkg::*;
#(
    parameter int CDR = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    // Command: accepted on any cycle with cmd_valid && cmd_ready; cmd_ready is
    // high only in IDLE. Response: rsp_valid is a one-cycle pulse, no backpressure.
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_typ,
    input  logic [7:0] cmd_dat,
    output logic       rsp_valid,
    output logic [7:0] rsp_dat,
    output logic       rsp_prs,
    output logic       owr_oe,
    input  logic       owr_i,
    output state_t     dbg_state
);

    state_t     state, state_next;
    cmd_typ_t   typ_q, typ_next;
    logic [9:0] ph, ph_next;
    logic [2:0] bcnt, bcnt_next;
    logic [7:0] sh, sh_next;
    logic [7:0] acc, acc_next;
    logic [7:0] rsp_dat_next;
    logic       rx, rx_next;
    logic       prs_smp, prs_next;
    logic       rsp_prs_next;
    logic       oe_next;
    logic       clr;
    logic       tick;
    logic [1:0] sync;
    logic       owr_s;

    onewire_tick #(.CDR(CDR)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    // The line idles high through the pull-up, so the synchronizer resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], owr_i};
    end
    assign owr_s = sync[1];

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign dbg_state = state;

    always_comb begin
        state_next   = state;
        typ_next     = typ_q;
        ph_next      = ph;
        bcnt_next    = bcnt;
        sh_next      = sh;
        acc_next     = acc;
        rx_next      = rx;
        prs_next     = prs_smp;
        rsp_dat_next = rsp_dat;
        rsp_prs_next = rsp_prs;
        clr          = 1'b0;
        oe_next      = 1'b0;

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    clr      = 1'b1;
                    ph_next  = '0;
                    typ_next = cmd_typ_t'(cmd_typ);
                    acc_next = '0;
                    prs_next = 1'b0;
                    sh_next  = cmd_dat;
                    unique case (cmd_typ_t'(cmd_typ))
                        CMD_RESET: state_next = RST;
                        CMD_BYTE: begin
                            state_next = SLOT;
                            bcnt_next  = 3'd7;
                        end
                        CMD_BIT: begin
                            state_next = SLOT;
                            bcnt_next  = 3'd0;
                        end
                        default: begin
                            state_next   = DONE;
                            rsp_dat_next = '0;
                            rsp_prs_next = 1'b0;
                        end
                    endcase
                end
            end
            RST: begin
                if (tick) begin
                    ph_next = ph + 10'd1;
                    if (ph == T_RST_SMP - 10'd1) prs_next = !owr_s;
                    if (ph == T_RST_END - 10'd1) begin
                        state_next   = DONE;
                        rsp_dat_next = '0;
                        rsp_prs_next = prs_smp;
                    end
                end
            end
            SLOT: begin
                if (tick) begin
                    ph_next = ph + 10'd1;
                    // A write-0 slot forces rx low without looking at the line.
                    if (ph == T_SMP - 10'd1) rx_next = sh[0] & owr_s;
                    if (ph == T_SLOT - 10'd1) begin
                        ph_next  = '0;
                        acc_next = {rx, acc[7:1]};
                        sh_next  = sh >> 1;
                        if (bcnt == 3'd0) begin
                            state_next   = DONE;
                            rsp_prs_next = 1'b0;
                            rsp_dat_next = (typ_q == CMD_BIT) ? {7'b0, rx} : {rx, acc[7:1]};
                        end else begin
                            bcnt_next = bcnt - 3'd1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Drive level for the coming cycle, so owr_oe edges fall on tick boundaries.
        unique case (state_next)
            RST:     oe_next = (ph_next < T_RST_LOW);
            SLOT:    oe_next = (ph_next < (sh_next[0] ? T_W1_LOW : T_W0_LOW));
            default: oe_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            typ_q   <= CMD_RESET;
            ph      <= '0;
            bcnt    <= '0;
            sh      <= '0;
            acc     <= '0;
            rx      <= 1'b0;
            prs_smp <= 1'b0;
            rsp_dat <= '0;
            rsp_prs <= 1'b0;
            owr_oe  <= 1'b0;
        end else begin
            state   <= state_next;
            typ_q   <= typ_next;
            ph      <= ph_next;
            bcnt    <= bcnt_next;
            sh      <= sh_next;
            acc     <= acc_next;
            rx      <= rx_next;
            prs_smp <= prs_next;
            rsp_dat <= rsp_dat_next;
            rsp_prs <= rsp_prs_next;
            owr_oe  <= oe_next;
        end
    end

endmodule

// File: tb/tb_onewire_sequencer.sv
// Randomized bench for onewire_sequencer with a timed slave model on the line
// and a command-level reference model for responses, latency and pulse widths.
module tb_onewire_sequencer;
    import onewire_pkg::*;

    localparam int CDR = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_typ = 2'd3;
    logic [7:0] cmd_dat = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_dat;
    logic       rsp_prs;
    logic       owr_oe;
    logic       owr_i;
    state_t     dbg_state;

    onewire_sequencer #(.CDR(CDR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_typ   (cmd_typ),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .rsp_prs   (rsp_prs),
        .owr_oe    (owr_oe),
        .owr_i     (owr_i),
        .dbg_state (dbg_state)
    );

    // ---------------- slave model ----------------
    // Slave answers each slot with bit slot_idx of slave_byte (pulls low 30 us
    // from the master's falling edge for a 0) and gives a 120 us presence pulse
    // 30 us after a reset pulse. A long idle gap restarts the slot index.
    logic       slave_present = 1'b0;
    logic [7:0] slave_byte = 8'hFF;
    int low_cnt = 0;
    int hi_cnt = 1000000;
    int pull_cnt = 0;
    int pres_wait = 0;
    int slot_idx = 0;

    always @(posedge clk) begin
        int idx;
        if (owr_oe) begin
            low_cnt <= low_cnt + 1;
            hi_cnt  <= 0;
        end else begin
            low_cnt <= 0;
            hi_cnt  <= hi_cnt + 1;
        end
        if (pull_cnt != 0) pull_cnt <= pull_cnt - 1;
        if (pres_wait != 0) begin
            pres_wait <= pres_wait - 1;
            if (pres_wait == 1) pull_cnt <= 120 * CDR;
        end
        if (owr_oe && low_cnt == 0) begin
            idx = (hi_cnt > 100 * CDR) ? 0 : slot_idx + 1;
            slot_idx <= idx;
            if (idx < 8 && !slave_byte[idx[2:0]]) pull_cnt <= 30 * CDR;
        end
        if (!owr_oe && low_cnt >= 480 * CDR && slave_present) pres_wait <= 30 * CDR;
    end

    assign owr_i = !(owr_oe || (pull_cnt != 0));

    // ---------------- low-pulse monitor ----------------
    int pulse_q[$];
    int run_len = 0;
    always @(negedge clk) begin
        if (owr_oe) begin
            run_len <= run_len + 1;
        end else if (run_len != 0) begin
            pulse_q.push_back(run_len);
            run_len <= 0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [1:0] typ);
        case (typ)
            2'd0:    return 960 * CDR + 1;
            2'd1:    return 560 * CDR + 1;
            2'd2:    return 70 * CDR + 1;
            default: return 1;
        endcase
    endfunction

    // Reference model: read bit = write bit AND slave bit; presence = slave present.
    function automatic logic [8:0] model_rsp(input logic [1:0] typ, input logic [7:0] dat);
        case (typ)
            2'd0:    return {slave_present, 8'h00};
            2'd1:    return {1'b0, dat & slave_byte};
            2'd2:    return {8'h00, dat[0] & slave_byte[0]};
            default: return 9'h000;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic run_cmd(input logic [1:0] typ, input logic [7:0] dat);
        int t;
        int lat;
        int busy;
        int n_exp;
        logic [8:0] held;
        exp_q.push_back(model_rsp(typ, dat));
        repeat (130 * CDR) @(negedge clk);
        pulse_q.delete();
        cmd_valid = 1'b1;
        cmd_typ   = typ;
        cmd_dat   = dat;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_typ   = 2'($urandom_range(0, 3));
        cmd_dat   = 8'($urandom_range(0, 255));
        lat  = 1;
        busy = 0;
        while (!rsp_valid && lat < 5000) begin
            if (cmd_ready) busy++;
            @(negedge clk);
            lat++;
        end
        chk("rsp_seen", 32'(rsp_valid), 32'd1);
        chk("latency", 32'(lat), 32'(exp_latency(typ)));
        chk("busy_ready", 32'(busy), 32'd0);
        chk("rsp_data", 32'({rsp_prs, rsp_dat}), 32'(exp_q.pop_front()));
        n_exp = (typ == 2'd1) ? 8 : (typ == 2'd3) ? 0 : 1;
        chk("pulse_count", 32'(pulse_q.size()), 32'(n_exp));
        for (int i = 0; i < n_exp && i < pulse_q.size(); i++) begin
            if (typ == 2'd0) chk("rst_low", 32'(pulse_q[i]), 32'(480 * CDR));
            else chk("slot_low", 32'(pulse_q[i]), 32'((dat[i] ? 6 : 60) * CDR));
        end
        held = {rsp_prs, rsp_dat};
        @(negedge clk);
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("rsp_hold", 32'({rsp_prs, rsp_dat}), 32'(held));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int busy;
        int seen;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_oe", 32'(owr_oe), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_dat", 32'(rsp_dat), 32'd0);
        chk("rst_prs", 32'(rsp_prs), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;

        slave_present = 1'b1;
        run_cmd(2'd0, 8'h00);
        slave_present = 1'b0;
        run_cmd(2'd0, 8'h00);
        slave_byte = 8'hFF;
        run_cmd(2'd1, 8'h55);
        slave_byte = 8'hA3;
        run_cmd(2'd1, 8'hFF);
        run_cmd(2'd3, 8'h5A);

        for (int i = 0; i < 6; i++) begin
            slave_byte = 8'($urandom_range(0, 255));
            run_cmd(2'd1, 8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 4; i++) begin
            slave_byte = 8'($urandom_range(0, 255));
            run_cmd(2'd2, 8'($urandom_range(0, 255)));
        end
        slave_present = 1'($urandom_range(0, 1));
        run_cmd(2'd0, 8'($urandom_range(0, 255)));

        // Back-to-back BIT 1 then BIT 0 with cmd_valid held high.
        slave_byte = 8'hFF;
        repeat (130 * CDR) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_typ   = 2'd2;
        cmd_dat   = 8'h01;
        lat  = 0;
        busy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (cmd_ready) busy++;
        end while (!rsp_valid && lat < 5000);
        chk("b2b_lat1", 32'(lat), 32'(70 * CDR + 1));
        chk("b2b_dat1", 32'(rsp_dat), 32'h01);
        cmd_dat = 8'h00;
        @(negedge clk);
        chk("b2b_reaccept", 32'(cmd_ready), 32'd1);
        lat = 0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            lat++;
            if (cmd_ready) busy++;
        end while (!rsp_valid && lat < 5000);
        chk("b2b_lat2", 32'(lat), 32'(70 * CDR + 1));
        chk("b2b_dat2", 32'(rsp_dat), 32'h00);
        chk("b2b_busy", 32'(busy), 32'd0);

        // Abort a write-0 slot at ph = 30 with the asynchronous reset.
        repeat (130 * CDR) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_typ   = 2'd2;
        cmd_dat   = 8'h00;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (30 * CDR) @(negedge clk);
        chk("abort_pre_oe", 32'(owr_oe), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_oe", 32'(owr_oe), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (100 * CDR) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        slave_present = 1'b1;
        run_cmd(2'd0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
